// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester access sequencer for a 4-bit x 256-nibble RAM.
// Every access runs IDLE -> SETUP -> ACCESS -> DONE; the data bus is driven only during a write ACCESS.
module ram_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 4,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  inout  wire  [DATA_W-1:0] mem_data
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic                own_b_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                last_b_q;
  logic                grant_b_c;
  logic                latch_c;
  logic                mem_we_d, busy_d, a_ack_d, b_ack_d;

  // Round-robin favours whoever was not granted last; fixed mode always favours A.
  assign grant_b_c = b_req && (!a_req || (!FIXED_PRIO && !last_b_q));
  assign latch_c   = (state_q == IDLE) && (a_req || b_req);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (a_req || b_req) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode, one cycle ahead so the outputs come straight from flops
  always_comb begin
    mem_we_d = 1'b0;
    busy_d   = 1'b0;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;
    if (state_d != IDLE)   busy_d   = 1'b1;
    if (state_d == ACCESS) mem_we_d = we_q;
    if (state_d == DONE) begin
      a_ack_d = !own_b_q;
      b_ack_d = own_b_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we <= 1'b0;
      busy   <= 1'b0;
      a_ack  <= 1'b0;
      b_ack  <= 1'b0;
    end else begin
      mem_we <= mem_we_d;
      busy   <= busy_d;
      a_ack  <= a_ack_d;
      b_ack  <= b_ack_d;
    end
  end

  // Transaction latch: owner and its request fields are frozen on the edge leaving IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_b_q  <= 1'b0;
      we_q     <= 1'b0;
      mem_addr <= '0;
      wdata_q  <= '0;
      last_b_q <= 1'b1;
    end else if (latch_c) begin
      own_b_q  <= grant_b_c;
      we_q     <= grant_b_c ? b_we    : a_we;
      mem_addr <= grant_b_c ? b_addr  : a_addr;
      wdata_q  <= grant_b_c ? b_wdata : a_wdata;
      last_b_q <= grant_b_c;
    end
  end

  // Read data is captured into the owner's register on the edge that ends ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if ((state_q == ACCESS) && !we_q) begin
      if (own_b_q) b_rdata <= mem_data;
      else         a_rdata <= mem_data;
    end
  end

  assign mem_data = mem_we ? wdata_q : {DATA_W{1'bz}};

endmodule
